// File: rtl/screen_pkg.sv
// Shared constants, opcodes and FSM state type for the screen writer.
package screen_pkg;

    localparam int unsigned SCREEN_W = 32;
    localparam int unsigned SCREEN_H = 32;
    localparam int unsigned COORD_W  = 5;
    localparam int unsigned OP_W     = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_SET_X = 3'd1;
    localparam logic [OP_W-1:0] OP_SET_Y = 3'd2;
    localparam logic [OP_W-1:0] OP_DRAW  = 3'd3;
    localparam logic [OP_W-1:0] OP_ERASE = 3'd4;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd5;
    localparam logic [OP_W-1:0] OP_PUSH  = 3'd6;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VBL = 2'd1,
        ST_COPY     = 2'd2,
        ST_CLEAR    = 2'd3
    } state_e;

endpackage

// File: rtl/screen_writer_pixel_plane.sv
// 32x32 bit plane: one row write port, one bit write port, one registered row read.
// WRITE_FIRST selects whether the read returns the row with same-edge writes applied.
module pixel_plane
    import screen_pkg::*;
#(
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                row_we_i,
    input  logic [COORD_W-1:0]  row_waddr_i,
    input  logic [SCREEN_W-1:0] row_wdata_i,
    input  logic                bit_we_i,
    input  logic [COORD_W-1:0]  bit_x_i,
    input  logic [COORD_W-1:0]  bit_y_i,
    input  logic                bit_val_i,
    input  logic [COORD_W-1:0]  rd_addr_i,
    output logic [SCREEN_W-1:0] rd_data_o
);

    logic [SCREEN_H-1:0][SCREEN_W-1:0] mem_q, mem_d;
    logic [SCREEN_W-1:0]               rd_data_q, rd_data_d;

    // Next contents of the plane: row write first, then the single-bit write.
    always_comb begin
        mem_d = mem_q;
        if (row_we_i) begin
            mem_d[row_waddr_i] = row_wdata_i;
        end
        if (bit_we_i) begin
            mem_d[bit_y_i][bit_x_i] = bit_val_i;
        end
    end

    // Read source: post-write row for write-first planes, current row otherwise.
    always_comb begin
        rd_data_d = WRITE_FIRST ? mem_d[rd_addr_i] : mem_q[rd_addr_i];
    end

    // Storage and read register; the whole plane clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/screen_writer.sv
// CPU-side pixel writer with back/front double buffering and video row read-out.
module screen_writer
    import screen_pkg::*;
#(
    parameter bit COPY_ON_VBLANK = 1'b1
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_cmd_valid,
    output logic                O_cmd_ready,
    input  logic [OP_W-1:0]     I_cmd_op,
    input  logic [COORD_W-1:0]  I_cmd_data,
    output logic                O_pixel,
    output logic                O_pixel_valid,
    input  logic                I_vblank,
    input  logic [COORD_W-1:0]  I_row,
    output logic [SCREEN_W-1:0] O_row_data,
    output logic                O_busy,
    output logic                O_frame_done
);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]   row_q, row_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 pixel_q, pixel_d;
    logic                 pixel_valid_q, pixel_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 cmd_accept;
    logic                 last_row;
    logic                 back_bit_we;
    logic                 back_bit_val;
    logic                 back_row_we;
    logic                 front_row_we;
    logic [COORD_W-1:0]   back_raddr;
    logic [SCREEN_W-1:0]  back_rd_row;
    logic [SCREEN_W-1:0]  front_rd_row;

    assign cmd_accept = I_cmd_valid && ready_q;
    assign last_row   = (row_q == COORD_W'(SCREEN_H - 1));

    // Next-state, register updates and buffer write strobes.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        row_d         = row_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        back_bit_we   = 1'b0;
        back_bit_val  = 1'b0;
        back_row_we   = 1'b0;
        front_row_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (I_cmd_op)
                        OP_NOP:   ;
                        OP_SET_X: x_d = I_cmd_data;
                        OP_SET_Y: y_d = I_cmd_data;
                        OP_DRAW: begin
                            back_bit_we  = 1'b1;
                            back_bit_val = 1'b1;
                        end
                        OP_ERASE: begin
                            back_bit_we  = 1'b1;
                            back_bit_val = 1'b0;
                        end
                        OP_LOAD: begin
                            // back_rd_row already holds row Y including every earlier write
                            pixel_d       = back_rd_row[x_q];
                            pixel_valid_d = 1'b1;
                        end
                        OP_PUSH: begin
                            row_d = '0;
                            if (!COPY_ON_VBLANK || I_vblank) begin
                                state_d = ST_COPY;
                            end else begin
                                state_d = ST_WAIT_VBL;
                            end
                        end
                        OP_CLEAR: begin
                            row_d   = '0;
                            state_d = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_VBL: begin
                if (I_vblank) begin
                    row_d   = '0;
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                front_row_we = 1'b1;
                row_d        = COORD_W'(row_q + 1'b1);
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                back_row_we = 1'b1;
                row_d       = COORD_W'(row_q + 1'b1);
                if (last_row) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Back read prefetches the row needed next cycle: Y when idle, copy row otherwise.
        back_raddr = (state_d == ST_IDLE) ? y_d : row_d;
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            row_q         <= '0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_q         <= row_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    pixel_plane #(
        .WRITE_FIRST (1'b1)
    ) u_back (
        .clk_i       (I_clk),
        .rst_ni      (I_rst_n),
        .row_we_i    (back_row_we),
        .row_waddr_i (row_q),
        .row_wdata_i ('0),
        .bit_we_i    (back_bit_we),
        .bit_x_i     (x_q),
        .bit_y_i     (y_q),
        .bit_val_i   (back_bit_val),
        .rd_addr_i   (back_raddr),
        .rd_data_o   (back_rd_row)
    );

    pixel_plane #(
        .WRITE_FIRST (1'b0)
    ) u_front (
        .clk_i       (I_clk),
        .rst_ni      (I_rst_n),
        .row_we_i    (front_row_we),
        .row_waddr_i (row_q),
        .row_wdata_i (back_rd_row),
        .bit_we_i    (1'b0),
        .bit_x_i     ('0),
        .bit_y_i     ('0),
        .bit_val_i   (1'b0),
        .rd_addr_i   (I_row),
        .rd_data_o   (front_rd_row)
    );

    assign O_cmd_ready   = ready_q;
    assign O_busy        = busy_q;
    assign O_pixel       = pixel_q;
    assign O_pixel_valid = pixel_valid_q;
    assign O_frame_done  = frame_done_q;
    assign O_row_data    = front_rd_row;

endmodule

// File: tb/tb_screen_writer.sv
// Bench for screen_writer: frame-buffer model compared every cycle plus directed literals.
module tb_screen_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [4:0]  cmd_data = 5'd0;
    logic        vblank = 1'b0;
    logic [4:0]  io_row = 5'd0;
    logic        cmd_ready, pixel, pixel_valid, busy, frame_done;
    logic [31:0] row_data;

    logic        c2_valid = 1'b0;
    logic [2:0]  c2_op = 3'd0;
    logic [4:0]  c2_data = 5'd0;
    logic [4:0]  row2 = 5'd0;
    logic        cmd_ready2, pixel2, pixel_valid2, busy2, frame_done2;
    logic [31:0] row_data2;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    screen_writer #(.COPY_ON_VBLANK(1'b1)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready),
        .I_cmd_op(cmd_op), .I_cmd_data(cmd_data), .O_pixel(pixel), .O_pixel_valid(pixel_valid),
        .I_vblank(vblank), .I_row(io_row), .O_row_data(row_data), .O_busy(busy),
        .O_frame_done(frame_done)
    );

    screen_writer #(.COPY_ON_VBLANK(1'b0)) dut_imm (
        .I_clk(clk), .I_rst_n(rst_n), .I_cmd_valid(c2_valid), .O_cmd_ready(cmd_ready2),
        .I_cmd_op(c2_op), .I_cmd_data(c2_data), .O_pixel(pixel2), .O_pixel_valid(pixel_valid2),
        .I_vblank(1'b0), .I_row(row2), .O_row_data(row_data2), .O_busy(busy2),
        .O_frame_done(frame_done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-buffer model ----------------
    logic [31:0] back_m [32];
    logic [31:0] front_m [32];
    logic [4:0]  mx, my;
    logic        m_wait, m_copy_on, m_clear_on;
    logic [4:0]  m_copy_r, m_clear_r;
    logic        m_ready, m_busy, m_pix, m_pixv, m_done;
    logic [31:0] m_row;

    wire m_acc        = cmd_valid && m_ready;
    wire m_push       = m_acc && (cmd_op == 3'd6);
    wire m_start_copy = (m_push && vblank) || (m_wait && vblank);
    wire m_next_wait  = (m_push && !vblank) || (m_wait && !vblank);
    wire m_next_copy  = m_start_copy || (m_copy_on && (m_copy_r != 5'd31));
    wire m_next_clear = (m_acc && (cmd_op == 3'd7)) || (m_clear_on && (m_clear_r != 5'd31));
    wire m_next_busy  = m_next_wait || m_next_copy || m_next_clear;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                back_m[i]  <= '0;
                front_m[i] <= '0;
            end
            mx <= '0; my <= '0;
            m_wait <= 1'b0; m_copy_on <= 1'b0; m_clear_on <= 1'b0;
            m_copy_r <= '0; m_clear_r <= '0;
            m_ready <= 1'b0; m_busy <= 1'b0; m_pix <= 1'b0; m_pixv <= 1'b0; m_done <= 1'b0;
            m_row <= '0;
        end else begin
            m_row  <= front_m[io_row];
            m_pixv <= 1'b0;
            m_done <= 1'b0;
            if (m_copy_on) begin
                front_m[m_copy_r] <= back_m[m_copy_r];
                m_copy_r <= m_copy_r + 5'd1;
                if (m_copy_r == 5'd31) begin
                    m_copy_on <= 1'b0;
                    m_done    <= 1'b1;
                end
            end
            if (m_clear_on) begin
                back_m[m_clear_r] <= '0;
                m_clear_r <= m_clear_r + 5'd1;
                if (m_clear_r == 5'd31) m_clear_on <= 1'b0;
            end
            if (m_wait && vblank) begin
                m_wait    <= 1'b0;
                m_copy_on <= 1'b1;
                m_copy_r  <= '0;
            end
            if (m_acc) begin
                case (cmd_op)
                    3'd1: mx <= cmd_data;
                    3'd2: my <= cmd_data;
                    3'd3: back_m[my][mx] <= 1'b1;
                    3'd4: back_m[my][mx] <= 1'b0;
                    3'd5: begin m_pix <= back_m[my][mx]; m_pixv <= 1'b1; end
                    3'd6: begin
                        if (vblank) begin m_copy_on <= 1'b1; m_copy_r <= '0; end
                        else m_wait <= 1'b1;
                    end
                    3'd7: begin m_clear_on <= 1'b1; m_clear_r <= '0; end
                    default: ;
                endcase
            end
            m_ready <= !m_next_busy;
            m_busy  <= m_next_busy;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready",   32'(cmd_ready),   32'(m_ready));
            chk("busy",        32'(busy),        32'(m_busy));
            chk("pixel_valid", 32'(pixel_valid), 32'(m_pixv));
            chk("pixel",       32'(pixel),       32'(m_pix));
            chk("frame_done",  32'(frame_done),  32'(m_done));
            chk("row_data",    row_data,         m_row);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [2:0] op, input logic [4:0] d, output int edges);
        logic acc;
        acc = 1'b0; edges = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!acc && edges < 200) begin
            acc = cmd_ready;
            @(posedge clk); #1;
            edges++;
        end
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 5'd0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send2(input logic [2:0] op, input logic [4:0] d);
        logic acc;
        int   edges;
        acc = 1'b0; edges = 0;
        c2_valid = 1'b1; c2_op = op; c2_data = d;
        while (!acc && edges < 200) begin
            acc = cmd_ready2;
            @(posedge clk); #1;
            edges++;
        end
        c2_valid = 1'b0; c2_op = 3'd0; c2_data = 5'd0;
        if (!acc) chk("send2_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   e;
        int   n;
        logic got;

        // Reset state
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",    32'(cmd_ready),   32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_row_data", row_data,         32'd0);
        chk("rst_pixv",     32'(pixel_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Draw, load, erase, load at (3,5)
        send(3'd1, 5'd3, e);
        send(3'd2, 5'd5, e);
        send(3'd3, 5'd0, e);
        send(3'd5, 5'd0, e);
        chk("load_valid", 32'(pixel_valid), 32'd1);
        chk("load_drawn", 32'(pixel),       32'd1);
        @(posedge clk); #1;
        chk("load_valid_pulse", 32'(pixel_valid), 32'd0);
        chk("load_hold",        32'(pixel),       32'd1);
        send(3'd4, 5'd0, e);
        send(3'd5, 5'd0, e);
        chk("load_erased", 32'(pixel), 32'd0);

        // Corners, PUSH waiting for vblank
        send(3'd1, 5'd0, e);  send(3'd2, 5'd0, e);  send(3'd3, 5'd0, e);
        send(3'd1, 5'd31, e); send(3'd2, 5'd31, e); send(3'd3, 5'd0, e);
        vblank = 1'b0;
        send(3'd6, 5'd0, e);
        repeat (10) @(posedge clk);
        #1;
        chk("wait_vbl_busy", 32'(busy), 32'd1);
        vblank = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            io_row = 5'(n - 1);
            @(posedge clk); #1;
            n++;
            if (n == 4) vblank = 1'b0;
            got = frame_done;
        end
        chk("vbl_to_done_edges", 32'(n), 32'd33);
        io_row = 5'd31;
        @(posedge clk); #1;
        chk("front_row31", row_data, 32'h8000_0000);
        io_row = 5'd0;
        @(posedge clk); #1;
        chk("front_row0", row_data, 32'h0000_0001);

        // Command held while copying
        vblank = 1'b1;
        send(3'd6, 5'd0, e);
        send(3'd1, 5'd9, e);
        chk("held_cmd_edges", 32'(e), 32'd33);

        // CLEAR leaves front untouched
        send(3'd7, 5'd0, e);
        send(3'd1, 5'd31, e);
        chk("after_clear_edges", 32'(e), 32'd33);
        send(3'd2, 5'd31, e);
        send(3'd5, 5'd0, e);
        chk("clear_load_valid", 32'(pixel_valid), 32'd1);
        chk("clear_load",       32'(pixel),       32'd0);
        io_row = 5'd31;
        @(posedge clk); #1;
        chk("front_kept_row31", row_data, 32'h8000_0000);

        // Reset during copy at row 10
        send(3'd1, 5'd5, e); send(3'd2, 5'd5, e); send(3'd3, 5'd0, e);
        send(3'd6, 5'd0, e);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midcopy_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("midcopy_rst_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        io_row = 5'd0;
        @(posedge clk); #1;
        chk("midcopy_row0", row_data, 32'd0);
        io_row = 5'd5;
        @(posedge clk); #1;
        chk("midcopy_row5", row_data, 32'd0);
        repeat (30) @(posedge clk);
        #1;

        // Immediate-copy instance
        send2(3'd1, 5'd2); send2(3'd2, 5'd4); send2(3'd3, 5'd0);
        send2(3'd6, 5'd0);
        chk("imm_busy", 32'(busy2), 32'd1);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            got = frame_done2;
        end
        chk("imm_done_edges", 32'(n), 32'd32);
        chk("imm_ready", 32'(cmd_ready2), 32'd1);
        row2 = 5'd4;
        @(posedge clk); #1;
        chk("imm_row4", row_data2, 32'h0000_0004);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 Parameter: COPY_ON_VBLANK, default 1, meaning 1 = PUSH waits for I_vblank high before copying; 0 = copy starts immediately.
REQ-002 Port: I_clk  input  1  system clock; all state on rising edge.
REQ-003 Port: I_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: I_cmd_valid  input  1  command strobe from the CPU.
REQ-005 Port: O_cmd_ready  output  1  block accepts a command this cycle.
REQ-006 Port: I_cmd_op  input  3  opcode: 0 NOP, 1 SET_X, 2 SET_Y, 3 DRAW, 4 ERASE, 5 LOAD, 6 PUSH, 7 CLEAR.
REQ-007 Port: I_cmd_data  input  5  coordinate operand for SET_X and SET_Y; ignored otherwise.
REQ-008 Port: O_pixel  output  1  LOAD result (back-buffer bit at X,Y).
REQ-009 Port: O_pixel_valid  output  1  one-cycle pulse marking O_pixel valid.
REQ-010 Port: I_vblank  input  1  video vertical-blank indicator; treated as level.
REQ-011 Port: I_row  input  5  video-side front-buffer row address.
REQ-012 Port: O_row_data  output  32  front-buffer row I_row; bit n = pixel X=n.
REQ-013 Port: O_busy  output  1  high in any state other than IDLE.
REQ-014 Port: O_frame_done  output  1  one-cycle pulse when a PUSH copy completes.

Function
REQ-015 Storage: back buffer 32x32 bits (CPU-written); front buffer 32x32 bits (video-read); row index = Y, bit index = X.
REQ-016 Handshake: command accepted on the cycle where I_cmd_valid and O_cmd_ready are both high; O_cmd_ready equals (state == IDLE).
REQ-017 SET_X / SET_Y: latch I_cmd_data into the X / Y register; takes effect for commands on the next cycle.
REQ-018 DRAW / ERASE: set / clear back[Y][X] on the accept edge; no other bit changes.
REQ-019 LOAD: O_pixel = back[Y][X] and O_pixel_valid = 1 on the cycle after acceptance; O_pixel holds its value until the next LOAD.
REQ-020 FSM states: IDLE, WAIT_VBL, COPY, CLEAR.
REQ-021 PUSH accepted: go to WAIT_VBL if COPY_ON_VBLANK=1, else go to COPY with row counter = 0.
REQ-022 WAIT_VBL: go to COPY (row counter 0) on the first cycle I_vblank is high; if I_vblank is already high at acceptance, COPY begins the next cycle.
REQ-023 COPY: each cycle front[r] <= back[r], r increments; after r = 31, O_frame_done pulses on that same cycle and state returns to IDLE; total 32 cycles.
REQ-024 I_vblank falling during COPY: no effect; the copy completes.
REQ-025 CLEAR accepted: go to CLEAR; each cycle back[r] <= 0, r = 0..31; return to IDLE after r = 31 (32 cycles); front buffer untouched; no O_frame_done.
REQ-026 NOP: accepted with no effect.
REQ-027 Commands presented while O_busy is high are not accepted and are not queued.
REQ-028 Video read: O_row_data registered, latency 1 cycle from I_row; available in every state.
REQ-029 Simultaneous copy and read of the same row: the read returns the pre-copy value; the new value appears on the next read.
REQ-030 X and Y are 5 bits; values wrap naturally, and no out-of-range condition exists.

Reset
REQ-031 On I_rst_n low: both buffers cleared to 0, X = Y = 0, row counter = 0, state = IDLE.
REQ-032 Output values during reset: O_pixel = 0, O_pixel_valid = 0, O_row_data = 0, O_busy = 0, O_frame_done = 0, O_cmd_ready = 0 while I_rst_n is low, then 1 from the first clock after release.
REQ-033 Reset asserted mid-COPY or mid-CLEAR aborts the operation immediately; no O_frame_done pulse.

Structure
REQ-034 Shared package screen_pkg holds: opcode constants, state enum, constants SCREEN_W = 32 and SCREEN_H = 32.
REQ-035 One sub-module, pixel_plane (32x32 bit array: one row write port, one bit write port, one registered row read port), instantiated twice as back and front buffers.

Verification
REQ-036 SET_X 3, SET_Y 5, DRAW, LOAD -> O_pixel = 1 with O_pixel_valid one cycle after the LOAD accept; ERASE then LOAD -> O_pixel = 0.
REQ-037 DRAW at (0,0) and (31,31), PUSH with I_vblank = 0 for 10 cycles then 1 -> COPY starts next cycle, O_frame_done after 32 cycles; I_row = 31 gives O_row_data = 0x80000000, I_row = 0 gives 0x00000001.
REQ-038 Command held valid during COPY -> O_cmd_ready = 0 and not accepted; accepted on the first IDLE cycle.
REQ-039 CLEAR after drawing -> back buffer reads 0 after 32 cycles; front rows unchanged; no O_frame_done pulse.
REQ-040 I_rst_n pulsed low at COPY row 10 -> all O_row_data = 0, state IDLE, no O_frame_done.
REQ-041 COPY_ON_VBLANK = 0, PUSH with I_vblank = 0 -> copy starts immediately; O_frame_done 32 cycles after acceptance.
